blit_engine: RTL

Parametrised rectangle blitter: the bus-visible register file plus the execution engine behind it. A host on the 68000-style peripheral bus programs source/destination, strides, extent and opcode. The engine then runs word copies or fills through a single-outstanding memory master port, raising an interrupt on completion. It sits beside the VGA framebuffer arbiter as one more memory master.

---
 rtl/blit_engine_if.sv | 46 ++++
 rtl/blit_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/blit_engine_if.sv
// Bus interfaces for the rectangle blitter: the host register bus
// (host is master) and the memory port (engine is master).

interface blit_reg_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  enable;
  logic [3:0]            reg_addr;
  logic                  write;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  dtack;
  logic                  berr;

  modport master (
    output enable, reg_addr, write, reg_wdata,
    input  reg_rdata, dtack, berr
  );

  modport slave (
    input  enable, reg_addr, write, reg_wdata,
    output reg_rdata, dtack, berr
  );
endinterface

interface blit_mem_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/blit_engine.sv
// Rectangle blitter: host-programmable register file plus a row-major
// copy/fill engine driving a single-outstanding memory master port.

module blit_engine #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  blit_reg_if.slave   regs,
  blit_mem_if.master  mem,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ADV} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  src_lo, src_hi, dst_lo, dst_hi;
  logic [DATA_WIDTH-1:0]  src_stride, dst_stride, opcode, fill;
  logic [COUNT_WIDTH-1:0] cols, rows, col, row;
  logic                   busy, done, err, last, op_copy;
  logic [ADDR_WIDTH-1:0]  src_base, dst_base;

  logic                   req_q, we_q, dtack_q, berr_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;

  logic [ADDR_WIDTH-1:0]  src_addr, dst_addr, cur_dst_addr;
  logic [ADDR_WIDTH-1:0]  next_src_base, next_dst_base, next_src_addr, next_dst_addr;
  logic [COUNT_WIDTH-1:0] next_col, next_row;
  logic                   row_end, is_last, acked;
  logic [DATA_WIDTH-1:0]  read_val;

  assign src_addr = ADDR_WIDTH'({src_hi, src_lo});
  assign dst_addr = ADDR_WIDTH'({dst_hi, dst_lo});
  assign acked    = mem.mem_ack && req_q;

  // Next-element address generation (row-major, wrapping arithmetic)
  always_comb begin
    row_end       = (col == cols - COUNT_WIDTH'(1));
    is_last       = row_end && (row == rows - COUNT_WIDTH'(1));
    next_col      = row_end ? '0 : col + COUNT_WIDTH'(1);
    next_row      = row_end ? row + COUNT_WIDTH'(1) : row;
    next_src_base = row_end ? src_base + ADDR_WIDTH'(src_stride) : src_base;
    next_dst_base = row_end ? dst_base + ADDR_WIDTH'(dst_stride) : dst_base;
    next_src_addr = next_src_base + ADDR_WIDTH'(next_col);
    next_dst_addr = next_dst_base + ADDR_WIDTH'(next_col);
    cur_dst_addr  = dst_base + ADDR_WIDTH'(col);
  end

  // Register read multiplexer
  always_comb begin
    read_val = '0;
    case (regs.reg_addr)
      4'd0:    read_val = src_lo;
      4'd1:    read_val = src_hi;
      4'd2:    read_val = dst_lo;
      4'd3:    read_val = dst_hi;
      4'd4:    read_val = src_stride;
      4'd5:    read_val = dst_stride;
      4'd6:    read_val = DATA_WIDTH'(cols);
      4'd7:    read_val = DATA_WIDTH'(rows);
      4'd8:    read_val = opcode;
      4'd9:    read_val = DATA_WIDTH'({err, done, busy});
      4'd10:   read_val = fill;
      default: read_val = '0;
    endcase
  end

  // Register access, operation start and the transfer state machine
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      src_lo     <= '0;
      src_hi     <= '0;
      dst_lo     <= '0;
      dst_hi     <= '0;
      src_stride <= '0;
      dst_stride <= '0;
      opcode     <= '0;
      fill       <= '0;
      cols       <= '0;
      rows       <= '0;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      last       <= 1'b0;
      op_copy    <= 1'b0;
      src_base   <= '0;
      dst_base   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;

      if (regs.enable) begin
        rdata_q <= regs.write ? '0 : read_val;
        if (regs.write && busy) begin
          berr_q <= 1'b1;
        end else begin
          dtack_q <= 1'b1;
        end

        if (regs.write && !busy) begin
          case (regs.reg_addr)
            4'd0:  src_lo     <= regs.reg_wdata;
            4'd1:  src_hi     <= regs.reg_wdata;
            4'd2:  dst_lo     <= regs.reg_wdata;
            4'd3:  dst_hi     <= regs.reg_wdata;
            4'd4:  src_stride <= regs.reg_wdata;
            4'd5:  dst_stride <= regs.reg_wdata;
            4'd6:  cols       <= COUNT_WIDTH'(regs.reg_wdata);
            4'd7:  rows       <= COUNT_WIDTH'(regs.reg_wdata);
            4'd9: begin
              done <= 1'b0;
              err  <= 1'b0;
            end
            4'd10: fill       <= regs.reg_wdata;
            4'd8: begin
              opcode <= regs.reg_wdata;
              if (regs.reg_wdata == DATA_WIDTH'(1) || regs.reg_wdata == DATA_WIDTH'(2)) begin
                done     <= 1'b0;
                err      <= 1'b0;
                busy     <= 1'b1;
                col      <= '0;
                row      <= '0;
                src_base <= src_addr;
                dst_base <= dst_addr;
                op_copy  <= (regs.reg_wdata == DATA_WIDTH'(1));
                // An empty rectangle parks in ADV for one cycle so busy
                // is visible for exactly one cycle before done.
                if (cols == '0 || rows == '0) begin
                  state <= S_ADV;
                  last  <= 1'b1;
                end else begin
                  last  <= 1'b0;
                  req_q <= 1'b1;
                  if (regs.reg_wdata == DATA_WIDTH'(1)) begin
                    state  <= S_READ;
                    we_q   <= 1'b0;
                    addr_q <= src_addr;
                  end else begin
                    state   <= S_WRITE;
                    we_q    <= 1'b1;
                    addr_q  <= dst_addr;
                    wdata_q <= fill;
                  end
                end
              end else if (regs.reg_wdata != '0) begin
                err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      case (state)
        S_IDLE: ;
        S_READ: begin
          if (acked) begin
            wdata_q <= mem.mem_rdata;
            we_q    <= 1'b1;
            addr_q  <= cur_dst_addr;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (acked) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            last  <= is_last;
            state <= S_ADV;
          end
        end
        S_ADV: begin
          if (last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            col      <= next_col;
            row      <= next_row;
            src_base <= next_src_base;
            dst_base <= next_dst_base;
            req_q    <= 1'b1;
            if (op_copy) begin
              state  <= S_READ;
              we_q   <= 1'b0;
              addr_q <= next_src_addr;
            end else begin
              state   <= S_WRITE;
              we_q    <= 1'b1;
              addr_q  <= next_dst_addr;
              wdata_q <= fill;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign regs.reg_rdata = rdata_q;
  assign regs.dtack     = dtack_q;
  assign regs.berr      = berr_q;
  assign mem.mem_req    = req_q;
  assign mem.mem_write  = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_wdata  = wdata_q;
  assign irq            = done;

endmodule
